// File: rtl/wb_pkg.sv
// Shared constants for the writeback stage: default widths and the
// source index map. Index order is program order for captures that
// land in the same cycle, so EX must stay below LSU.
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int RF_ADDR_W  = 5;
    localparam int WB_NUM_SRC = 2;

    localparam int WB_SRC_EX  = 0;
    localparam int WB_SRC_LSU = 1;
    localparam int WB_SRC_MD  = 2;

endpackage

// File: rtl/wb_age_arb.sv
// Oldest-first arbiter over NUM_SRC slots using an older-than matrix.
// Latency: grant is combinational from registered age/valid state; matrix updates on capture.
// Backpressure: none here; the parent throttles sources by freeing slots only on grant.
module wb_age_arb
    import wb_pkg::*;
#(
    parameter int NUM_SRC = WB_NUM_SRC
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_SRC-1:0]               valid_i,
    input  logic [NUM_SRC-1:0]               capture_i,
    output logic [NUM_SRC-1:0]               grant_o,
    output logic [NUM_SRC-1:0][NUM_SRC-1:0]  older_o
);

    // older_q[i][j] = 1 means slot i holds an entry older than slot j
    logic [NUM_SRC-1:0][NUM_SRC-1:0] older_q, older_d;

    assign older_o = older_q;

    // A captured slot becomes younger than every held entry; same-cycle captures order by index
    always_comb begin
        older_d = older_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (capture_i[i]) begin
                for (int j = 0; j < NUM_SRC; j++) begin
                    if (j != i) begin
                        if (capture_i[j]) begin
                            older_d[i][j] = (i < j);
                        end else begin
                            older_d[i][j] = 1'b0;
                            older_d[j][i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Age matrix register, cleared on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            older_q <= '0;
        end else begin
            older_q <= older_d;
        end
    end

    // Grant the valid slot that is older than every other valid slot
    always_comb begin
        grant_o = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            grant_o[i] = valid_i[i];
            for (int j = 0; j < NUM_SRC; j++) begin
                if (j != i && valid_i[j] && !older_q[i][j]) begin
                    grant_o[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/wb_multi_src_arb.sv
// Merges NUM_SRC writeback sources through one-entry slots onto a registered RF write port.
// Latency: accept in N, slot valid/grant in N+1, rf_we_o in N+2; forwarding is combinational.
// Backpressure: src_ready_o is low only while a held slot waits behind older entries.
module wb_multi_src_arb
    import wb_pkg::*;
#(
    parameter int NUM_SRC = WB_NUM_SRC,
    parameter int DATA_W  = XLEN,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int NUM_FWD = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_SRC-1:0]               src_valid_i,
    output logic [NUM_SRC-1:0]               src_ready_o,
    input  logic [NUM_SRC-1:0]               src_we_i,
    input  logic [NUM_SRC-1:0][ADDR_W-1:0]   src_waddr_i,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]   src_wdata_i,
    output logic                             rf_we_o,
    output logic [ADDR_W-1:0]                rf_waddr_o,
    output logic [DATA_W-1:0]                rf_wdata_o,
    input  logic [NUM_FWD-1:0][ADDR_W-1:0]   fwd_addr_i,
    output logic [NUM_FWD-1:0]               fwd_hit_o,
    output logic [NUM_FWD-1:0][DATA_W-1:0]   fwd_data_o,
    output logic                             busy_o
);

    logic [NUM_SRC-1:0]               slot_vld_q, slot_vld_d;
    logic [NUM_SRC-1:0][ADDR_W-1:0]   slot_addr_q, slot_addr_d;
    logic [NUM_SRC-1:0][DATA_W-1:0]   slot_data_q, slot_data_d;
    logic [NUM_SRC-1:0]               grant, accept, load;
    logic [NUM_SRC-1:0][NUM_SRC-1:0]  older;
    logic                             rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]                rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]                rf_wdata_q, rf_wdata_d;
    logic [NUM_FWD-1:0][NUM_SRC-1:0]  fwd_match, fwd_sel;

    // Ready comes from registered state only: empty slot, or slot draining this cycle
    assign src_ready_o = ~slot_vld_q | grant;
    assign accept      = src_valid_i & src_ready_o;

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign busy_o     = (|slot_vld_q) | rf_we_q;

    // Only real writes occupy a slot; x0 and non-writing requests are dropped on accept
    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            load[i] = accept[i] & src_we_i[i] & (src_waddr_i[i] != '0);
        end
    end

    wb_age_arb #(
        .NUM_SRC (NUM_SRC)
    ) u_age_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .valid_i   (slot_vld_q),
        .capture_i (load),
        .grant_o   (grant),
        .older_o   (older)
    );

    // Slot next state: a granted slot frees and may be refilled in the same cycle
    always_comb begin
        slot_vld_d  = slot_vld_q & ~grant;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (load[i]) begin
                slot_vld_d[i]  = 1'b1;
                slot_addr_d[i] = src_waddr_i[i];
                slot_data_d[i] = src_wdata_i[i];
            end
        end
    end

    // RF stage next state: one-hot OR-mux of the granted slot, zero when idle
    always_comb begin
        rf_we_d    = |grant;
        rf_waddr_d = '0;
        rf_wdata_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                rf_waddr_d = rf_waddr_d | slot_addr_q[i];
                rf_wdata_d = rf_wdata_d | slot_data_q[i];
            end
        end
    end

    // Slot and RF output registers; reset discards pending entries without a write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_vld_q  <= '0;
            slot_addr_q <= '0;
            slot_data_q <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
        end else begin
            slot_vld_q  <= slot_vld_d;
            slot_addr_q <= slot_addr_d;
            slot_data_q <= slot_data_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

    // Per forwarding port: which valid slots hold the queried non-zero address
    always_comb begin
        fwd_match = '0;
        for (int p = 0; p < NUM_FWD; p++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                fwd_match[p][i] = slot_vld_q[i] && (fwd_addr_i[p] != '0)
                                  && (slot_addr_q[i] == fwd_addr_i[p]);
            end
        end
    end

    // Keep only the youngest matching slot: every other match must be older than it
    always_comb begin
        fwd_sel = '0;
        for (int p = 0; p < NUM_FWD; p++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                fwd_sel[p][i] = fwd_match[p][i];
                for (int j = 0; j < NUM_SRC; j++) begin
                    if (j != i && fwd_match[p][j] && !older[j][i]) begin
                        fwd_sel[p][i] = 1'b0;
                    end
                end
            end
        end
    end

    // Forward the youngest slot hit, else the RF stage, else nothing
    always_comb begin
        fwd_hit_o  = '0;
        fwd_data_o = '0;
        for (int p = 0; p < NUM_FWD; p++) begin
            if (|fwd_sel[p]) begin
                fwd_hit_o[p] = 1'b1;
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (fwd_sel[p][i]) begin
                        fwd_data_o[p] = fwd_data_o[p] | slot_data_q[i];
                    end
                end
            end else if (rf_we_q && (fwd_addr_i[p] != '0) && (rf_waddr_q == fwd_addr_i[p])) begin
                fwd_hit_o[p]  = 1'b1;
                fwd_data_o[p] = rf_wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_wb_multi_src_arb.sv
module tb_wb_multi_src_arb;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [1:0]        src_valid = '0;
    logic [1:0]        src_ready;
    logic [1:0]        src_we = '0;
    logic [1:0][4:0]   src_waddr = '0;
    logic [1:0][31:0]  src_wdata = '0;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;
    logic [1:0][4:0]   fwd_addr = '0;
    logic [1:0]        fwd_hit;
    logic [1:0][31:0]  fwd_data;
    logic              busy;

    int n_chk = 0;
    int n_err = 0;

    wb_multi_src_arb #(
        .NUM_SRC (2),
        .DATA_W  (32),
        .ADDR_W  (5),
        .NUM_FWD (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .src_valid_i (src_valid),
        .src_ready_o (src_ready),
        .src_we_i    (src_we),
        .src_waddr_i (src_waddr),
        .src_wdata_i (src_wdata),
        .rf_we_o     (rf_we),
        .rf_waddr_o  (rf_waddr),
        .rf_wdata_o  (rf_wdata),
        .fwd_addr_i  (fwd_addr),
        .fwd_hit_o   (fwd_hit),
        .fwd_data_o  (fwd_data),
        .busy_o      (busy)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input int idx, input logic we, input logic [4:0] a, input logic [31:0] d);
        src_valid[idx] = 1'b1;
        src_we[idx]    = we;
        src_waddr[idx] = a;
        src_wdata[idx] = d;
    endtask

    task automatic idle();
        src_valid = '0;
        src_we    = '0;
        src_waddr = '0;
        src_wdata = '0;
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_we"}, rf_we, we);
        if (we) begin
            chk({tag, "_addr"}, rf_waddr, a);
            chk({tag, "_data"}, rf_wdata, d);
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_we", rf_we, 0);
        chk("rst_addr", rf_waddr, 0);
        chk("rst_data", rf_wdata, 0);
        chk("rst_rdy", src_ready, 2'b11);
        chk("rst_busy", busy, 0);
        fwd_addr[0] = 5'd5;
        fwd_addr[1] = 5'd0;
        #1;
        chk("rst_hit", fwd_hit, 2'b00);
        tick();
        #3 rst_ni = 1'b1;
        tick();

        // Single write x5=0x11: visible two edges after capture
        drive(0, 1'b1, 5'd5, 32'h11);
        tick();
        idle();
        chk("t1_rdy_n1", src_ready, 2'b11);
        chk("t1_we_n1", rf_we, 0);
        chk("t1_busy_n1", busy, 1);
        tick();
        chk_rf("t1_n2", 1'b1, 5'd5, 32'h11);
        chk("t1_rdy_n2", src_ready, 2'b11);
        tick();
        chk("t1_we_n3", rf_we, 0);
        chk("t1_busy_n3", busy, 0);

        // Same-cycle captures to x7: lower index retires first
        drive(0, 1'b1, 5'd7, 32'hA);
        drive(1, 1'b1, 5'd7, 32'hB);
        tick();
        idle();
        chk("t2_rdy_n1", src_ready, 2'b01);
        tick();
        chk_rf("t2_n2", 1'b1, 5'd7, 32'hA);
        chk("t2_rdy_n2", src_ready, 2'b11);
        tick();
        chk_rf("t2_n3", 1'b1, 5'd7, 32'hB);
        tick();
        chk("t2_we_n4", rf_we, 0);
        chk("t2_busy_n4", busy, 0);

        // src1 then src0 on x3 in consecutive cycles: capture order holds
        drive(1, 1'b1, 5'd3, 32'h1);
        tick();
        idle();
        chk("t3_rdy_n1", src_ready, 2'b11);
        drive(0, 1'b1, 5'd3, 32'h2);
        tick();
        idle();
        chk_rf("t3_n2", 1'b1, 5'd3, 32'h1);
        chk("t3_rdy_n2", src_ready[0], 1);
        tick();
        chk_rf("t3_n3", 1'b1, 5'd3, 32'h2);
        tick();
        chk("t3_we_n4", rf_we, 0);

        // Forwarding: x9=0x55 held in src1 (older), x9=0x66 held in src0 (younger)
        drive(0, 1'b1, 5'd1, 32'h1);
        drive(1, 1'b1, 5'd9, 32'h55);
        tick();
        idle();
        drive(0, 1'b1, 5'd9, 32'h66);
        tick();
        idle();
        chk_rf("t4_n2", 1'b1, 5'd1, 32'h1);
        chk("t4_rdy_n2", src_ready, 2'b10);
        fwd_addr[0] = 5'd9;
        fwd_addr[1] = 5'd0;
        #1;
        chk("t4_hit_a", fwd_hit, 2'b01);
        chk("t4_data_9", fwd_data[0], 32'h66);
        chk("t4_data_0", fwd_data[1], 32'h0);
        fwd_addr[1] = 5'd1;
        #1;
        chk("t4_hit_rf", fwd_hit, 2'b11);
        chk("t4_data_rf", fwd_data[1], 32'h1);
        tick();
        chk_rf("t4_n3", 1'b1, 5'd9, 32'h55);
        chk("t4_hit_n3", fwd_hit[0], 1);
        chk("t4_data_n3", fwd_data[0], 32'h66);
        chk("t4_hit1_n3", fwd_hit[1], 0);
        tick();
        chk_rf("t4_n4", 1'b1, 5'd9, 32'h66);
        chk("t4_data_n4", fwd_data[0], 32'h66);
        tick();
        chk("t4_hit_n5", fwd_hit, 2'b00);
        chk("t4_fdata_n5", fwd_data[0], 32'h0);

        // Discarded requests: waddr=0 on src0, we=0 on src1
        drive(0, 1'b1, 5'd0, 32'hDEAD);
        drive(1, 1'b0, 5'd4, 32'hBEEF);
        #1;
        chk("t5_rdy_pre", src_ready, 2'b11);
        tick();
        idle();
        chk("t5_busy_n1", busy, 0);
        chk("t5_rdy_n1", src_ready, 2'b11);
        chk("t5_we_n1", rf_we, 0);
        tick();
        chk("t5_we_n2", rf_we, 0);
        chk("t5_busy_n2", busy, 0);

        // Reset with both slots full and a write in flight
        drive(0, 1'b1, 5'd10, 32'h1);
        drive(1, 1'b1, 5'd11, 32'h2);
        tick();
        idle();
        drive(0, 1'b1, 5'd12, 32'h3);
        tick();
        idle();
        chk_rf("t6_pre", 1'b1, 5'd10, 32'h1);
        chk("t6_busy_pre", busy, 1);
        chk("t6_rdy_pre", src_ready, 2'b10);
        fwd_addr[0] = 5'd12;
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_we_rst", rf_we, 0);
        chk("t6_addr_rst", rf_waddr, 0);
        chk("t6_data_rst", rf_wdata, 0);
        chk("t6_rdy_rst", src_ready, 2'b11);
        chk("t6_busy_rst", busy, 0);
        chk("t6_hit_rst", fwd_hit, 2'b00);
        #2 rst_ni = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t6_stale_we%0d", k), rf_we, 0);
            chk($sformatf("t6_stale_busy%0d", k), busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_multi_src_arb.md
# wb_multi_src_arb

Parametrised writeback stage merging NUM_SRC register-file write sources (EX, LSU, later MUL/DIV, CSR) onto one registered RF write port. Each source has a one-entry holding slot behind a valid/ready handshake. An oldest-first arbiter picks one slot per cycle, so same-address writes retire in capture order. Forwarding query ports expose pending data to the ID stage. The block sits between the EX/LSU outputs and the register file.

## Interface
- NUM_SRC, 2, number of write sources; index 0 = EX, 1 = LSU, higher = future units
- DATA_W, 32, RF data width
- ADDR_W, 5, RF address width
- NUM_FWD, 2, number of forwarding query ports
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- src_valid_i  in  NUM_SRC  per-source request valid
- src_ready_o  out  NUM_SRC  per-source slot can accept
- src_we_i  in  NUM_SRC  request actually writes RF
- src_waddr_i  in  NUM_SRC x ADDR_W  destination register
- src_wdata_i  in  NUM_SRC x DATA_W  write data
- rf_we_o  out  1  registered RF write enable
- rf_waddr_o  out  ADDR_W  registered RF write address
- rf_wdata_o  out  DATA_W  registered RF write data
- fwd_addr_i  in  NUM_FWD x ADDR_W  ID read addresses to check
- fwd_hit_o  out  NUM_FWD  pending write to that address exists
- fwd_data_o  out  NUM_FWD x DATA_W  newest pending data for that address
- busy_o  out  1  any slot occupied or rf_we_o high

## Operation
- Slot i holds {valid, addr, data}. Accept on src_valid_i[i] & src_ready_o[i].
- src_ready_o[i] = ~slot_valid[i] | grant[i]. It depends only on registered state, never on src_valid_i.
- An accepted request with src_we_i=0 or waddr=0 is consumed and discarded: the slot is not loaded and no RF write occurs.
- Age: NUM_SRC x NUM_SRC older-than matrix, updated on capture. A newly captured entry is younger than every entry already held.
- Captures in the same cycle: lower index is older. Program order must map to index order; the EX/LSU pairing guarantees this.
- Grant: exactly one held slot per cycle, namely the one older than all other valid slots. No grant when all slots are empty.
- The granted slot's contents are registered into rf_*_o the next cycle. The slot is freed in the same cycle it is granted and may be refilled in that cycle.
- Forwarding, per port: compare fwd_addr_i against all valid slots and the rf_*_o stage.
  - The youngest matching slot wins. The rf_*_o stage has lowest priority.
  - Address 0 never hits. On no hit, fwd_hit_o=0 and fwd_data_o=0.
  - Purely combinational.
- No overflow is possible, because the per-slot handshake throttles each source. A source stalls only while its slot is still waiting behind older entries.

## Timing
- Reset values:
  - rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
  - All slots invalid; age matrix cleared.
  - src_ready_o = all ones. busy_o=0. fwd_hit_o=0.
- Latency: accepted in cycle N, slot valid in N+1, earliest grant in N+1, rf_we_o high in N+2.
- rf_we_o is a one-cycle pulse per write. Throughput is one RF write per cycle.
- Worst-case wait for a slot is NUM_SRC-1 cycles behind older entries. There is no starvation.
- Simultaneous grant and refill of the same slot: the new entry becomes youngest.
- Reset mid-operation: pending slots are discarded without an RF write, and outputs return to reset values asynchronously.

## Structure
- Package wb_pkg holds:
  - default constants: XLEN=32, RF_ADDR_W=5, WB_NUM_SRC=2
  - source index localparams: WB_SRC_EX=0, WB_SRC_LSU=1, WB_SRC_MD=2
- Sub-module wb_age_arb: age-matrix oldest-first arbiter.
  - Inputs: valid vector, capture vector.
  - Output: one-hot grant.
- The top level contains the slots, the output register, and the forwarding compare.

## Test plan
- Reset, then src0 writes x5=0x11 in cycle 1 → rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x11 in cycle 3; src_ready_o stays 11.
- src0 writes x7=0xA and src1 writes x7=0xB in the same cycle → x7=0xA in cycle N+2, then x7=0xB in cycle N+3.
- src1 captures x3=0x1, then next cycle src0 captures x3=0x2 → 0x1 written first, then 0x2; src0 sees ready=1 throughout.
- While x9=0x55 is held in src1 and x9=0x66 is held in src0 (younger) → fwd_addr_i=9 gives fwd_hit_o=1 and fwd_data_o=0x66; fwd_addr_i=0 gives no hit.
- src0 request with waddr=0, and a request with src_we_i=0 → both accepted, no rf_we_o pulse, busy_o stays 0.
- Both slots full, rst_ni asserted mid-cycle → rf_we_o=0 and src_ready_o=11 immediately; after release, no stale write appears.
